cpu_datapath: RTL and testbench

CPU_DATAPATH -- requirements
Module: cpu_datapath

---
 rtl/cpu_datapath_pkg.sv | 16 +
 rtl/cpu_alu.sv | 26 ++
 rtl/cpu_datapath.sv | 106 ++++++++++
 tb/tb_cpu_datapath.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_datapath_pkg.sv
// Shared constants for the datapath and the control unit: register widths and ALU opcodes.
package cpu_datapath_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_INC  = 4'b0010;
    localparam logic [3:0] ALU_ZERO = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOT  = 4'b0111;

endpackage

// File: rtl/cpu_alu.sv
// Combinational 8-bit ALU; carries are dropped and unknown opcodes pass A through.
module cpu_alu
    import cpu_datapath_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        alus,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = a;
        case (alus)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_INC:  y = a + 8'd1;
            ALU_ZERO: y = '0;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_NOT:  y = ~a;
            default:  y = a;
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// Accumulator-CPU datapath: prioritised 16-bit internal bus, architectural registers,
// ALU instance and a sticky bus-contention flag.
module cpu_datapath
    import cpu_datapath_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              arload,
    input  logic              pcload,
    input  logic              pcinc,
    input  logic              drload,
    input  logic              trload,
    input  logic              irload,
    input  logic              rload,
    input  logic              acload,
    input  logic              zload,
    input  logic              pcbus,
    input  logic              drhbus,
    input  logic              drlbus,
    input  logic              trbus,
    input  logic              rbus,
    input  logic              acbus,
    input  logic              zbus,
    input  logic              membus,
    input  logic              busmem,
    input  logic [3:0]        alus,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] ir,
    output logic              z,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] ar,
    output logic [DATA_W-1:0] ac,
    output logic [DATA_W-1:0] r,
    output logic              bus_conflict
);

    logic [DATA_W-1:0] dr;
    logic [DATA_W-1:0] tr;
    logic [ADDR_W-1:0] bus;
    logic [DATA_W-1:0] alu_y;
    logic [6:0]        srcs;
    logic              multi_src;

    cpu_alu u_alu (
        .a    (ac),
        .b    (r),
        .alus (alus),
        .y    (alu_y)
    );

    always_comb begin
        bus = '0;
        if (membus)
            bus = {8'h00, mem_rdata};
        else if (pcbus)
            bus = pc;
        else if (drhbus || trbus)
            bus = {drhbus ? dr : 8'h00, trbus ? tr : 8'h00};
        else if (drlbus)
            bus = {8'h00, dr};
        else if (rbus)
            bus = {8'h00, r};
        else if (acbus)
            bus = {8'h00, ac};
        else if (zbus)
            bus = {15'b0, z};
    end

    // drhbus/trbus together form one source; clearing the lowest set bit leaves
    // something behind only when two or more sources are active.
    assign srcs      = {membus, pcbus, drhbus | trbus, drlbus, rbus, acbus, zbus};
    assign multi_src = (srcs & (srcs - 7'd1)) != 7'd0;

    assign mem_addr  = ar;
    assign mem_wdata = busmem ? bus[DATA_W-1:0] : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= '0;
            ar           <= '0;
            dr           <= '0;
            tr           <= '0;
            ir           <= '0;
            r            <= '0;
            ac           <= '0;
            z            <= 1'b0;
            bus_conflict <= 1'b0;
        end else begin
            if (arload) ar <= bus;
            if (pcload)
                pc <= bus;
            else if (pcinc)
                pc <= pc + 16'd1;
            if (drload) dr <= bus[DATA_W-1:0];
            if (trload) tr <= dr;
            if (irload) ir <= dr;
            if (rload)  r  <= bus[DATA_W-1:0];
            if (acload) ac <= membus ? bus[DATA_W-1:0] : alu_y;
            if (zload)  z  <= (alu_y == 8'h00);
            if (multi_src) bus_conflict <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: a register-level reference model checked every cycle,
// plus literal expectations taken from worked examples.
module tb_cpu_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        arload, pcload, pcinc, drload, trload, irload, rload, acload, zload;
    logic        pcbus, drhbus, drlbus, trbus, rbus, acbus, zbus, membus, busmem;
    logic [3:0]  alus;
    logic [7:0]  mem_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  ir;
    logic        z;
    logic [15:0] pc, ar;
    logic [7:0]  ac, r;
    logic        bus_conflict;

    localparam logic [17:0] C_ARLOAD = 18'd1 << 0;
    localparam logic [17:0] C_PCLOAD = 18'd1 << 1;
    localparam logic [17:0] C_PCINC  = 18'd1 << 2;
    localparam logic [17:0] C_DRLOAD = 18'd1 << 3;
    localparam logic [17:0] C_TRLOAD = 18'd1 << 4;
    localparam logic [17:0] C_IRLOAD = 18'd1 << 5;
    localparam logic [17:0] C_RLOAD  = 18'd1 << 6;
    localparam logic [17:0] C_ACLOAD = 18'd1 << 7;
    localparam logic [17:0] C_ZLOAD  = 18'd1 << 8;
    localparam logic [17:0] C_PCBUS  = 18'd1 << 9;
    localparam logic [17:0] C_DRHBUS = 18'd1 << 10;
    localparam logic [17:0] C_DRLBUS = 18'd1 << 11;
    localparam logic [17:0] C_TRBUS  = 18'd1 << 12;
    localparam logic [17:0] C_RBUS   = 18'd1 << 13;
    localparam logic [17:0] C_ACBUS  = 18'd1 << 14;
    localparam logic [17:0] C_ZBUS   = 18'd1 << 15;
    localparam logic [17:0] C_MEMBUS = 18'd1 << 16;
    localparam logic [17:0] C_BUSMEM = 18'd1 << 17;
    localparam logic [17:0] C_IDLE   = 18'd0;

    int nChecks = 0;
    int nFails  = 0;
    bit checkEn = 1'b0;

    int mPc, mAr, mDr, mTr, mIr, mR, mAc, mZ, mConf;

    cpu_datapath dut (
        .clk(clk), .rst(rst),
        .arload(arload), .pcload(pcload), .pcinc(pcinc), .drload(drload), .trload(trload),
        .irload(irload), .rload(rload), .acload(acload), .zload(zload),
        .pcbus(pcbus), .drhbus(drhbus), .drlbus(drlbus), .trbus(trbus), .rbus(rbus),
        .acbus(acbus), .zbus(zbus), .membus(membus), .busmem(busmem),
        .alus(alus), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .ir(ir), .z(z),
        .pc(pc), .ar(ar), .ac(ac), .r(r), .bus_conflict(bus_conflict)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Bus value as the model sees it, from the current model registers and inputs.
    function automatic int modelBus();
        if (membus)               return mem_rdata;
        if (pcbus)                return mPc;
        if (drhbus || trbus)      return (drhbus ? mDr * 256 : 0) + (trbus ? mTr : 0);
        if (drlbus)               return mDr;
        if (rbus)                 return mR;
        if (acbus)                return mAc;
        if (zbus)                 return mZ;
        return 0;
    endfunction

    function automatic int modelAlu();
        int a = mAc;
        int b = mR;
        if (alus == 4'd0) return (a + b) % 256;
        if (alus == 4'd1) return (a - b + 256) % 256;
        if (alus == 4'd2) return (a + 1) % 256;
        if (alus == 4'd3) return 0;
        if (alus == 4'd4) return a & b;
        if (alus == 4'd5) return a | b;
        if (alus == 4'd6) return a ^ b;
        if (alus == 4'd7) return 255 - a;
        return a;
    endfunction

    function automatic int sourceCount();
        return int'(membus) + int'(pcbus) + int'(drhbus || trbus) + int'(drlbus)
             + int'(rbus) + int'(acbus) + int'(zbus);
    endfunction

    // Drive one cycle of control, wait for the edge, then advance the model from pre-edge values.
    task automatic applyStimulus(input logic [17:0] ctl, input logic [3:0] op, input logic [7:0] rd, input logic rs);
        int b, y, oldDr;
        rst = rs; alus = op; mem_rdata = rd;
        arload = ctl[0];  pcload = ctl[1];  pcinc  = ctl[2];  drload = ctl[3];
        trload = ctl[4];  irload = ctl[5];  rload  = ctl[6];  acload = ctl[7];
        zload  = ctl[8];  pcbus  = ctl[9];  drhbus = ctl[10]; drlbus = ctl[11];
        trbus  = ctl[12]; rbus   = ctl[13]; acbus  = ctl[14]; zbus   = ctl[15];
        membus = ctl[16]; busmem = ctl[17];
        @(posedge clk);
        if (rs) begin
            mPc = 0; mAr = 0; mDr = 0; mTr = 0; mIr = 0; mR = 0; mAc = 0; mZ = 0; mConf = 0;
        end else begin
            b = modelBus();
            y = modelAlu();
            oldDr = mDr;
            if (arload) mAr = b;
            if (pcload) mPc = b;
            else if (pcinc) mPc = (mPc + 1) % 65536;
            if (drload) mDr = b % 256;
            if (trload) mTr = oldDr;
            if (irload) mIr = oldDr;
            if (rload)  mR = b % 256;
            if (acload) mAc = membus ? b % 256 : y;
            if (zload)  mZ = (y == 0) ? 1 : 0;
            if (sourceCount() >= 2) mConf = 1;
        end
        #1;
    endtask

    // Continuous comparison of every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("pc", pc, 16'(mPc));
            checkOutput("ar", ar, 16'(mAr));
            checkOutput("memAddr", mem_addr, 16'(mAr));
            checkOutput("ir", {8'h00, ir}, 16'(mIr));
            checkOutput("r", {8'h00, r}, 16'(mR));
            checkOutput("ac", {8'h00, ac}, 16'(mAc));
            checkOutput("z", {15'b0, z}, 16'(mZ));
            checkOutput("busConflict", {15'b0, bus_conflict}, 16'(mConf));
            checkOutput("memWdata", {8'h00, mem_wdata}, busmem ? 16'(modelBus() % 256) : 16'h0000);
        end
    end

    initial begin
        // Reset with every strobe high must still clear everything.
        applyStimulus(18'h3FFFF, 4'd0, 8'hFF, 1'b1);
        checkEn = 1'b1;
        checkOutput("rstPc", pc, 16'h0000);
        checkOutput("rstAc", {8'h00, ac}, 16'h0000);
        checkOutput("rstConflict", {15'b0, bus_conflict}, 16'h0000);
        applyStimulus(C_IDLE, 4'd0, 8'h00, 1'b0);

        // PC = FFFF via {DR,TR}, then increment wraps.
        applyStimulus(C_DRLOAD | C_MEMBUS, 4'd0, 8'hFF, 1'b0);
        applyStimulus(C_DRLOAD | C_TRLOAD | C_MEMBUS, 4'd0, 8'hFF, 1'b0);
        applyStimulus(C_PCLOAD | C_DRHBUS | C_TRBUS, 4'd0, 8'h00, 1'b0);
        checkOutput("pcLoadFFFF", pc, 16'hFFFF);
        applyStimulus(C_PCINC, 4'd0, 8'h00, 1'b0);
        checkOutput("pcWrap", pc, 16'h0000);

        // PC = 1234, then pcload beats pcinc.
        applyStimulus(C_DRLOAD | C_MEMBUS, 4'd0, 8'h34, 1'b0);
        applyStimulus(C_DRLOAD | C_TRLOAD | C_MEMBUS, 4'd0, 8'h12, 1'b0);
        applyStimulus(C_PCLOAD | C_DRHBUS | C_TRBUS, 4'd0, 8'h00, 1'b0);
        checkOutput("pcLoad1234", pc, 16'h1234);
        applyStimulus(C_PCLOAD | C_PCINC | C_MEMBUS, 4'd0, 8'h56, 1'b0);
        checkOutput("pcLoadWins", pc, 16'h0056);

        // Address fetch: DR=12 -> DR=34, TR=12, then AR = {DR,TR}; IR takes old DR.
        applyStimulus(C_DRLOAD | C_TRLOAD | C_MEMBUS, 4'd0, 8'h34, 1'b0);
        applyStimulus(C_ARLOAD | C_DRHBUS | C_TRBUS | C_IRLOAD, 4'd0, 8'h00, 1'b0);
        checkOutput("addrFetch", mem_addr, 16'h3412);
        checkOutput("irFromDr", {8'h00, ir}, 16'h0034);
        applyStimulus(C_ARLOAD | C_DRLBUS | C_BUSMEM, 4'd0, 8'h00, 1'b0);
        checkOutput("arFromDrl", ar, 16'h0034);

        // Subtract to zero, then add.
        applyStimulus(C_RLOAD | C_MEMBUS, 4'd0, 8'h05, 1'b0);
        applyStimulus(C_ACLOAD | C_MEMBUS, 4'd0, 8'h05, 1'b0);
        applyStimulus(C_ACLOAD | C_ZLOAD, 4'd1, 8'h00, 1'b0);
        checkOutput("subAc", {8'h00, ac}, 16'h0000);
        checkOutput("subZ", {15'b0, z}, 16'h0001);
        applyStimulus(C_ACLOAD | C_MEMBUS, 4'd0, 8'h05, 1'b0);
        applyStimulus(C_ACLOAD | C_ZLOAD, 4'd0, 8'h00, 1'b0);
        checkOutput("addAc", {8'h00, ac}, 16'h000A);
        checkOutput("addZ", {15'b0, z}, 16'h0000);

        // Increment wrap and NOT.
        applyStimulus(C_ACLOAD | C_MEMBUS, 4'd0, 8'hFF, 1'b0);
        applyStimulus(C_ACLOAD, 4'd2, 8'h00, 1'b0);
        checkOutput("incWrap", {8'h00, ac}, 16'h0000);
        applyStimulus(C_ACLOAD, 4'd7, 8'h00, 1'b0);
        checkOutput("notAc", {8'h00, ac}, 16'h00FF);

        // Logic ops on AC=3C, R=0F; bus transfers with busmem exercise mem_wdata.
        applyStimulus(C_RLOAD | C_MEMBUS, 4'd0, 8'h0F, 1'b0);
        applyStimulus(C_ACLOAD | C_MEMBUS, 4'd0, 8'h3C, 1'b0);
        applyStimulus(C_ACLOAD | C_ZLOAD, 4'd4, 8'h00, 1'b0);
        checkOutput("andAc", {8'h00, ac}, 16'h000C);
        applyStimulus(C_ACLOAD, 4'd5, 8'h00, 1'b0);
        applyStimulus(C_ACLOAD, 4'd6, 8'h00, 1'b0);
        applyStimulus(C_ACLOAD, 4'd10, 8'h00, 1'b0);
        checkOutput("defaultOpHoldsA", {8'h00, ac}, 16'h0000);
        applyStimulus(C_ACLOAD | C_MEMBUS, 4'd0, 8'hA5, 1'b0);
        applyStimulus(C_ACLOAD | C_ZLOAD, 4'd3, 8'h00, 1'b0);
        applyStimulus(C_RLOAD | C_ZBUS | C_BUSMEM, 4'd0, 8'h00, 1'b0);
        applyStimulus(C_ACBUS | C_BUSMEM, 4'd0, 8'h00, 1'b0);
        applyStimulus(C_RBUS | C_BUSMEM | C_ARLOAD, 4'd0, 8'h00, 1'b0);
        applyStimulus(C_TRBUS | C_BUSMEM | C_ARLOAD, 4'd0, 8'h00, 1'b0);

        // Contention: PC wins the bus, flag is sticky until reset.
        applyStimulus(C_PCBUS | C_ACBUS | C_ARLOAD | C_BUSMEM, 4'd0, 8'h00, 1'b0);
        checkOutput("conflictPriority", ar, 16'h0056);
        checkOutput("conflictSet", {15'b0, bus_conflict}, 16'h0001);
        for (int i = 0; i < 3; i++) applyStimulus(C_IDLE, 4'd0, 8'h00, 1'b0);
        checkOutput("conflictSticky", {15'b0, bus_conflict}, 16'h0001);

        // Reset raised between edges leaves state alone until the edge (checked at negedge).
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(C_IDLE, 4'd0, 8'h00, 1'b1);
        checkOutput("conflictCleared", {15'b0, bus_conflict}, 16'h0000);
        checkOutput("pcCleared", pc, 16'h0000);
        applyStimulus(C_IDLE, 4'd0, 8'h00, 1'b0);
        @(negedge clk);
        checkEn = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
